// File: rtl/fifo_word_packer.sv
// fifo_word_packer: gathers RATIO narrow beats (little-endian) into one
// WIDTH-bit word and pushes it into the downstream shift-register FIFO,
// never pushing while the FIFO reports full. A flush closes a partial word
// early with the unwritten upper bits left at zero.
module fifo_word_packer #(
  parameter int WIDTH    = 8,
  parameter int IN_WIDTH = 2,
  parameter int RATIO    = WIDTH / IN_WIDTH,
  parameter int CNTWID   = $clog2(RATIO + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  input  logic                full,
  output logic                push,
  output logic [WIDTH-1:0]    data_in,
  output logic [CNTWID-1:0]   beat_count
);

  // FILL: word under assembly. HOLD: completed word waiting for FIFO space.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNTWID-1:0]   count_q, count_d;
  logic [WIDTH-1:0]    word_q, word_d;

  logic                accept;
  logic                last_beat;
  logic [WIDTH-1:0]    beat_at_count;
  logic [WIDTH-1:0]    beat_at_zero;

  // A completed word leaves as soon as the FIFO has room. Accepting a new beat
  // in that same cycle keeps streaming bubble-free. in_ready is gated by rst
  // so nothing is taken while reset is held.
  assign push       = (state_q == HOLD) & ~full;
  assign in_ready   = rst & ((state_q == FILL) | push);
  assign accept     = in_valid & in_ready;
  assign data_in    = word_q;
  assign beat_count = count_q;

  // The beat that completes the word is the one landing in the top slot.
  assign last_beat    = (count_q == CNTWID'(RATIO - 1));
  // During overlap the incoming beat opens a fresh word at slot 0.
  assign beat_at_zero = WIDTH'(in_data);

  // Steer the incoming beat into the slot selected by the beat counter.
  always_comb begin
    beat_at_count = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (count_q == CNTWID'(k)) begin
        beat_at_count[k*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
  end

  // Next-state, counter and word update for the FILL/HOLD controller.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          // Unwritten slots are still zero, so OR-ing in the beat is enough.
          word_d = word_q | beat_at_count;
          if (last_beat || flush) begin
            // A flush on the final beat closes the same word: one push only.
            state_d = HOLD;
            count_d = '0;
          end else begin
            count_d = count_q + CNTWID'(1);
          end
        end else if (flush && (count_q != '0)) begin
          // Close a partial word; the upper slots are already zero padding.
          state_d = HOLD;
          count_d = '0;
        end
      end
      HOLD: begin
        if (push) begin
          if (accept) begin
            word_d = beat_at_zero;
            if (flush) begin
              // The single new beat is itself closed as a padded word.
              state_d = HOLD;
              count_d = '0;
            end else begin
              state_d = FILL;
              count_d = CNTWID'(1);
            end
          end else begin
            word_d  = '0;
            state_d = FILL;
            count_d = '0;
          end
        end
        // With full asserted everything holds and flush has no effect.
      end
      default: begin
        state_d = FILL;
        count_d = '0;
        word_d  = '0;
      end
    endcase
  end

  // State registers; reset discards any partial or pending word immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

endmodule
